dffasr_mbit_scan_ret: RTL and testbench

//  Parametrised multi-bit D flip-flop with asynchronous active-low reset and set.

---
 rtl/dffasr_mbit_scan_ret.sv | 84 ++++++++
 tb/tb_dffasr_mbit_scan_ret.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dffasr_mbit_scan_ret.sv
// Multi-bit DFF with async reset/set, clock enable, mux-scan and retention.
// Ports: CLK, RSTB, SETB, RET, SE, SI, EN, D[W] in; Q[W], QN[W], SO out.
module dffasr_mbit_scan_ret #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] SET_MASK = '1
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic             SETB,
  input  logic             RET,
  input  logic             SE,
  input  logic             SI,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QN,
  output logic             SO
);

  logic             clr_n;
  logic             set_n;
  logic             dual;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] nxt;

  // Retention masks every async control.
  // Reset holds whenever RSTB is low, so entering
  // dual assert clears S; set-only is decoded as
  // its own level so that leaving dual assert via
  // RSTB produces the falling edge that sets S.
  assign clr_n = RSTB | RET;
  assign set_n = ~(RSTB & ~SETB & ~RET);
  assign dual  = ~RSTB & ~SETB & ~RET;

  always_comb begin
    sh    = '0;
    sh[0] = SI;
    for (int i = 1; i < WIDTH; i++) begin
      sh[i] = s[i-1];
    end
  end

  always_comb begin
    nxt = s;
    if (RET) begin
      nxt = s;
    end else if (SE) begin
      nxt = sh;
    end else if (EN) begin
      nxt = D;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic b;
    if (SET_MASK[gi]) begin : g_set
      always_ff @(posedge CLK or negedge clr_n or negedge set_n) begin
        if (!clr_n) begin
          b <= 1'b0;
        end else if (!set_n) begin
          b <= 1'b1;
        end else begin
          b <= nxt[gi];
        end
      end
    end else begin : g_nset
      always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
          b <= 1'b0;
        end else begin
          b <= nxt[gi];
        end
      end
    end
    assign s[gi] = b;
  end

  // Legacy dual-assert: masked bits drive Q=0 and QN=0.
  assign Q  = s;
  assign QN = ~s & ~({WIDTH{dual}} & SET_MASK);
  assign SO = s[WIDTH-1];

endmodule

// File: tb/tb_dffasr_mbit_scan_ret.sv
// Scoreboard bench for dffasr_mbit_scan_ret.
// Two instances: full set mask (a) and mask 0011 (b).
module tb_dffasr_mbit_scan_ret;

  logic       CLK = 1'b0;
  logic       RSTB = 1'b0;
  logic       SETB = 1'b1;
  logic       RET = 1'b0;
  logic       SE = 1'b0;
  logic       SI = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] D = 4'b0000;
  logic [3:0] qa, qna, qb, qnb;
  logic       soa, sob;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string      name;
    bit         sel;
    logic [3:0] q;
    logic [3:0] qn;
    logic       so;
  } exp_t;

  exp_t sb[$];
  event smp;

  dffasr_mbit_scan_ret #(.WIDTH(4)) ua (
    .CLK(CLK), .RSTB(RSTB), .SETB(SETB), .RET(RET),
    .SE(SE), .SI(SI), .EN(EN), .D(D),
    .Q(qa), .QN(qna), .SO(soa)
  );

  dffasr_mbit_scan_ret #(.WIDTH(4), .SET_MASK(4'b0011)) ub (
    .CLK(CLK), .RSTB(RSTB), .SETB(SETB), .RET(RET),
    .SE(SE), .SI(SI), .EN(EN), .D(D),
    .Q(qb), .QN(qnb), .SO(sob)
  );

  always #5 CLK = ~CLK;

  // Monitor: samples 1 time unit after each strobe.
  initial begin
    forever begin
      @(smp);
      #1;
      while (sb.size() > 0) begin
        exp_t e;
        logic [3:0] aq, aqn;
        logic       aso;
        e   = sb.pop_front();
        aq  = e.sel ? qb : qa;
        aqn = e.sel ? qnb : qna;
        aso = e.sel ? sob : soa;
        checks++;
        if (aq === e.q && aqn === e.qn && aso === e.so) begin
          passed++;
        end else begin
          $display("FAIL %s: got Q=%b QN=%b SO=%b need Q=%b QN=%b SO=%b",
                   e.name, aq, aqn, aso, e.q, e.qn, e.so);
        end
      end
    end
  end

  task automatic expect_out(input string n, input bit sel,
                            input logic [3:0] q, input logic [3:0] qn);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.q    = q;
    e.qn   = qn;
    e.so   = q[3];
    sb.push_back(e);
  endtask

  task automatic strobe();
    -> smp;
    #2;
  endtask

  task automatic edge_clk();
    @(posedge CLK);
  endtask

  task automatic to_neg();
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "timeout");
  end

  initial begin
    #1;
    // 1 reset
    expect_out("pwrup_a", 0, 4'b0000, 4'b1111);
    expect_out("pwrup_b", 1, 4'b0000, 4'b1111);
    strobe();
    to_neg();
    EN = 1'b1; D = 4'b1010;
    edge_clk(); edge_clk();
    expect_out("rst_clk", 0, 4'b0000, 4'b1111);
    strobe();

    // 2 load / hold
    to_neg();
    RSTB = 1'b1;
    edge_clk();
    expect_out("load", 0, 4'b1010, 4'b0101);
    strobe();
    to_neg();
    EN = 1'b0; D = 4'b0101;
    edge_clk();
    expect_out("hold", 0, 4'b1010, 4'b0101);
    strobe();

    // 3 scan from 0000, EN ignored
    to_neg();
    RSTB = 1'b0; #1; RSTB = 1'b1;
    SE = 1'b1; EN = 1'b1; D = 4'b1111;
    SI = 1'b1; edge_clk();
    expect_out("scan1", 0, 4'b0001, 4'b1110);
    strobe();
    to_neg(); SI = 1'b0; edge_clk();
    expect_out("scan2", 0, 4'b0010, 4'b1101);
    strobe();
    to_neg(); SI = 1'b1; edge_clk();
    expect_out("scan3", 0, 4'b0101, 4'b1010);
    strobe();
    to_neg(); SI = 1'b1; edge_clk();
    expect_out("scan4", 0, 4'b1011, 4'b0100);
    strobe();
    // reset mid-shift then shift a 0 in
    to_neg();
    RSTB = 1'b0;
    expect_out("scan_rst", 0, 4'b0000, 4'b1111);
    strobe();
    RSTB = 1'b1; SI = 1'b0;
    edge_clk();
    expect_out("scan_after", 0, 4'b0000, 4'b1111);
    strobe();

    // 4 dual assert
    to_neg();
    SE = 1'b0; EN = 1'b0;
    RSTB = 1'b0; SETB = 1'b0;
    expect_out("dual_b", 1, 4'b0000, 4'b1100);
    expect_out("dual_a", 0, 4'b0000, 4'b0000);
    strobe();
    RSTB = 1'b1;
    expect_out("dual_rrel_b", 1, 4'b0011, 4'b1100);
    expect_out("dual_rrel_a", 0, 4'b1111, 4'b0000);
    strobe();
    SETB = 1'b1;
    expect_out("dual_srel_b", 1, 4'b0011, 4'b1100);
    strobe();
    // other release order: S stays cleared
    RSTB = 1'b0; SETB = 1'b0; #1;
    SETB = 1'b1;
    expect_out("dual_srel_first", 1, 4'b0000, 4'b1111);
    strobe();
    RSTB = 1'b1;
    expect_out("dual_then_rrel", 1, 4'b0000, 4'b1111);
    strobe();

    // 5 retention
    to_neg();
    EN = 1'b1; D = 4'b1010;
    edge_clk();
    to_neg();
    RET = 1'b1; #1;
    RSTB = 1'b0; D = 4'b0101;
    edge_clk(); edge_clk(); edge_clk();
    expect_out("ret_hold", 0, 4'b1010, 4'b0101);
    strobe();
    to_neg();
    RET = 1'b0;
    expect_out("ret_fall", 0, 4'b0000, 4'b1111);
    strobe();
    RSTB = 1'b1;

    // 6 set-only masked
    to_neg();
    EN = 1'b1; D = 4'b1000;
    edge_clk();
    to_neg();
    EN = 1'b0;
    SETB = 1'b0;
    expect_out("set_b", 1, 4'b1011, 4'b0100);
    expect_out("set_a", 0, 4'b1111, 4'b0000);
    strobe();
    to_neg();
    EN = 1'b1; D = 4'b0100;
    edge_clk();
    expect_out("set_clk_b", 1, 4'b0111, 4'b1000);
    expect_out("set_clk_a", 0, 4'b1111, 4'b0000);
    strobe();
    to_neg();
    SETB = 1'b1; EN = 1'b0;
    expect_out("set_rel_b", 1, 4'b0111, 4'b1000);
    strobe();

    #5;
    checks++;
    if (sb.size() == 0) begin
      passed++;
    end else begin
      $display("FAIL drain: got %0d pending need 0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
